// File: rtl/serial_mem_responder.sv
// Memory-side endpoint of the CPU's byte-serial memory link: assembles 16-bit request words,
// owns a word-addressed RAM and streams read/fetch responses back high byte first.
module serial_mem_responder #(
  parameter int    ADDR_W       = 8,
  parameter int    RESP_LATENCY = 2,
  parameter int    BYTE_GAP     = 1,
  parameter string MEM_FILE     = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] out_bus,
  input  logic       bus_pc,
  input  logic       bus_mar,
  input  logic       bus_mdr,
  input  logic       halt,
  output logic [7:0] in_bus,
  output logic       ard_data_ready,
  output logic       ard_receive_ready,
  output logic       proto_err
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int WAIT_W   = $clog2((RESP_LATENCY > 1) ? RESP_LATENCY : 1) + 1;
  localparam int GAP_W    = $clog2((BYTE_GAP > 1) ? BYTE_GAP : 1) + 1;
  localparam int GAP_LOAD = (BYTE_GAP > 0) ? BYTE_GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_LO, S_WAIT, S_TX_HI, S_GAP, S_TX_LO, S_HALTED
  } state_t;

  typedef enum logic [1:0] {TAG_PC, TAG_MAR, TAG_MDR} tag_t;

  state_t              state;
  state_t              done_state;
  tag_t                tag_q;
  tag_t                strobe_tag;
  logic [7:0]          hi_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [15:0]         resp_q;
  logic [15:0]         word;
  logic [ADDR_W-1:0]   word_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                halt_q;
  logic [2:0]          strobes;
  logic                one_strobe;
  logic                multi_strobe;
  logic                lo_match;
  logic                mem_we;
  logic [15:0]         mem [DEPTH];

  assign strobes      = {bus_mdr, bus_mar, bus_pc};
  assign one_strobe   = $onehot(strobes);
  assign multi_strobe = (strobes != 3'b000) && !one_strobe;
  assign word         = {hi_q, out_bus};
  assign word_idx     = word[ADDR_W-1:0];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    strobe_tag = TAG_PC;
    if (bus_mar)      strobe_tag = TAG_MAR;
    else if (bus_mdr) strobe_tag = TAG_MDR;
  end

  assign ard_receive_ready = (state == S_IDLE) || (state == S_RX_LO);
  assign lo_match   = (state == S_RX_LO) && one_strobe && (strobe_tag == tag_q);
  assign mem_we     = lo_match && (tag_q == TAG_MDR) && rst;
  // A halt seen at any point of a transaction parks the FSM once that transaction is finished.
  assign done_state = (halt_q || halt) ? S_HALTED : S_IDLE;

  // NOTE: the RAM has no reset branch; contents survive reset and the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mar_q] <= word;
  end

  // The fetch address needs no storage: the response word is captured as the request completes.
  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      tag_q          <= TAG_PC;
      hi_q           <= 8'h00;
      mar_q          <= '0;
      resp_q         <= 16'h0000;
      wait_cnt       <= '0;
      gap_cnt        <= '0;
      halt_q         <= 1'b0;
      in_bus         <= 8'h00;
      ard_data_ready <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      ard_data_ready <= 1'b0;
      if (halt && state != S_IDLE) halt_q <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (halt) begin
            state <= S_HALTED;
          end else if (multi_strobe) begin
            proto_err <= 1'b1;
          end else if (one_strobe) begin
            hi_q  <= out_bus;
            tag_q <= strobe_tag;
            state <= S_RX_LO;
          end
        end
        S_RX_LO: begin
          if (multi_strobe) begin
            proto_err <= 1'b1;
          end else if (one_strobe) begin
            if (strobe_tag != tag_q) begin
              proto_err <= 1'b1;
              state     <= done_state;
            end else if (tag_q == TAG_MDR) begin
              state <= done_state;
            end else begin
              if (tag_q == TAG_MAR) mar_q <= word_idx;
              resp_q   <= mem[word_idx];
              wait_cnt <= WAIT_W'(RESP_LATENCY);
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            in_bus         <= resp_q[15:8];
            ard_data_ready <= 1'b1;
            state          <= S_TX_HI;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        S_TX_HI: begin
          if (BYTE_GAP == 0) begin
            in_bus         <= resp_q[7:0];
            ard_data_ready <= 1'b1;
            state          <= S_TX_LO;
          end else begin
            gap_cnt <= GAP_W'(GAP_LOAD);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            in_bus         <= resp_q[7:0];
            ard_data_ready <= 1'b1;
            state          <= S_TX_LO;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_TX_LO:  state <= done_state;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_responder.sv
// Scoreboard bench: two responders (slow and zero-latency) share one request stream and are
// compared against a word-level model of the link and RAM.
module tb_serial_mem_responder;

  localparam int L_SLOW = 2;
  localparam int G_SLOW = 1;
  localparam int L_FAST = 0;
  localparam int G_FAST = 0;

  typedef enum {T_PC, T_MAR, T_MDR} tag_e;

  typedef struct {
    logic [15:0] word;
    bit          known;
    int          t_acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] out_bus;
  logic       bus_pc, bus_mar, bus_mdr, halt;
  logic [7:0] ib [2];
  logic       dr [2];
  logic       rr [2];
  logic       pe [2];

  serial_mem_responder #(.ADDR_W(8), .RESP_LATENCY(L_SLOW), .BYTE_GAP(G_SLOW)) u_slow (
    .clk(clk), .rst(rst), .out_bus(out_bus), .bus_pc(bus_pc), .bus_mar(bus_mar),
    .bus_mdr(bus_mdr), .halt(halt), .in_bus(ib[0]), .ard_data_ready(dr[0]),
    .ard_receive_ready(rr[0]), .proto_err(pe[0]));

  serial_mem_responder #(.ADDR_W(8), .RESP_LATENCY(L_FAST), .BYTE_GAP(G_FAST)) u_fast (
    .clk(clk), .rst(rst), .out_bus(out_bus), .bus_pc(bus_pc), .bus_mar(bus_mar),
    .bus_mdr(bus_mdr), .halt(halt), .in_bus(ib[1]), .ard_data_ready(dr[1]),
    .ard_receive_ready(rr[1]), .proto_err(pe[1]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: RAM image, MAR and sticky error flag at word level.
  logic [15:0] ref_mem   [256];
  bit          ref_valid [256];
  logic [7:0]  ref_mar;
  bit          ref_perr;
  int          written [$];

  exp_t exp_q [2][$];
  int   phase [2];
  int   t_hi  [2];
  exp_t cur   [2];

  function automatic int lat(input int i);
    return (i == 0) ? L_SLOW : L_FAST;
  endfunction

  function automatic int gapc(input int i);
    return (i == 0) ? G_SLOW : G_FAST;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the expected word on each response high byte and checks both bytes and timing.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dr[i] === 1'b1) begin
        if (phase[i] == 0) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_resp%0d", i), 1, 0);
          end else begin
            cur[i] = exp_q[i].pop_front();
            if (cur[i].known) check($sformatf("resp_hi%0d", i), ib[i], cur[i].word[15:8]);
            check($sformatf("hi_latency%0d", i), cyc - cur[i].t_acc, lat(i) + 1);
            check($sformatf("ready_in_tx_hi%0d", i), rr[i], 0);
            t_hi[i]  = cyc;
            phase[i] = 1;
          end
        end else begin
          if (cur[i].known) check($sformatf("resp_lo%0d", i), ib[i], cur[i].word[7:0]);
          check($sformatf("byte_gap%0d", i), cyc - t_hi[i], gapc(i) + 1);
          check($sformatf("ready_in_tx_lo%0d", i), rr[i], 0);
          phase[i] = 0;
        end
      end
    end
  end

  task automatic send_byte(input tag_e tag, input logic [7:0] data, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rr[0] === 1'b1 && rr[1] === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 0, 1);
    out_bus = data;
    bus_pc  = (tag == T_PC);
    bus_mar = (tag == T_MAR);
    bus_mdr = (tag == T_MDR);
    @(negedge clk);
    t       = cyc;
    bus_pc  = 1'b0;
    bus_mar = 1'b0;
    bus_mdr = 1'b0;
  endtask

  task automatic push_resp(input logic [7:0] idx, input int t);
    exp_t e;
    e.word  = ref_mem[idx];
    e.known = ref_valid[idx];
    e.t_acc = t;
    exp_q[0].push_back(e);
    exp_q[1].push_back(e);
  endtask

  task automatic send_word(input tag_e tag, input logic [15:0] w);
    int t;
    send_byte(tag, w[15:8], t);
    send_byte(tag, w[7:0], t);
    case (tag)
      T_MDR: begin
        ref_mem[ref_mar] = w;
        if (!ref_valid[ref_mar]) written.push_back(int'(ref_mar));
        ref_valid[ref_mar] = 1'b1;
      end
      T_MAR: begin
        ref_mar = w[7:0];
        push_resp(w[7:0], t);
      end
      default: push_resp(w[7:0], t);
    endcase
  endtask

  task automatic wait_idle(input bit rdy_exp);
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || phase[0] != 0 || phase[1] != 0)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("response_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("receive_ready%0d", i), rr[i], rdy_exp);
      check($sformatf("proto_err%0d", i), pe[i], ref_perr);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_in_bus%0d", tag, i), ib[i], 8'h00);
      check($sformatf("%s_data_ready%0d", tag, i), dr[i], 0);
      check($sformatf("%s_proto_err%0d", tag, i), pe[i], 0);
      check($sformatf("%s_receive_ready%0d", tag, i), rr[i], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [7:0]  idx;
    logic [15:0] w;
    rst = 1'b0; halt = 1'b0; out_bus = 8'h00;
    bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0;
    ref_mar = 8'h00; ref_perr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 16'h0000;
      ref_valid[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) phase[i] = 0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Write/read through MAR then MDR; the first MAR read returns a not-yet-written word.
    send_word(T_MAR, 16'h0005);
    send_word(T_MDR, 16'hBEEF);
    send_word(T_MAR, 16'h0005);
    wait_idle(1'b1);

    // Fetch with ignored upper address bits.
    send_word(T_MDR, 16'h1234);
    send_word(T_PC, 16'h0105);
    wait_idle(1'b1);

    // Randomized writes and reads of previously written locations.
    for (int k = 0; k < 40; k++) begin
      if (written.size() == 0 || $urandom_range(2, 0) == 0) begin
        idx = 8'($urandom);
        send_word(T_MAR, {8'($urandom), idx});
        send_word(T_MDR, 16'($urandom));
      end else begin
        idx = 8'(written[$urandom_range(written.size() - 1, 0)]);
        if ($urandom_range(1, 0) == 1) send_word(T_PC, {8'($urandom), idx});
        else                           send_word(T_MAR, {8'($urandom), idx});
      end
      if (k % 8 == 7) wait_idle(1'b1);
    end
    wait_idle(1'b1);

    // Two strobes at once in IDLE: byte dropped, error raised, FSM still idle.
    @(negedge clk);
    out_bus = 8'h55; bus_pc = 1'b1; bus_mdr = 1'b1;
    @(negedge clk);
    bus_pc = 1'b0; bus_mdr = 1'b0;
    ref_perr = 1'b1;
    send_word(T_MAR, 16'h0005);
    wait_idle(1'b1);

    // Async reset in the middle of an MDR word: no RAM write, outputs cleared without a clock.
    send_word(T_MAR, 16'h0009);
    send_word(T_MDR, 16'h5A5A);
    send_byte(T_MDR, 8'hDE, t);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    ref_mar = 8'h00; ref_perr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_word(T_MDR, 16'h7777);
    send_word(T_MAR, 16'h0009);
    send_word(T_MAR, 16'h0000);
    wait_idle(1'b1);

    // Tag mismatch between high and low byte.
    send_byte(T_MAR, 8'h00, t);
    send_byte(T_PC, 8'h09, t);
    ref_perr = 1'b1;
    @(negedge clk);
    check("mismatch_proto_err0", pe[0], 1);
    check("mismatch_proto_err1", pe[1], 1);
    send_word(T_MAR, 16'h0009);
    wait_idle(1'b1);

    // Halt during WAIT: response completes, then the responder stays parked.
    send_word(T_MAR, 16'h3309);
    halt = 1'b1;
    wait_idle(1'b0);
    for (int k = 0; k < 10; k++) begin
      out_bus = 8'($urandom);
      bus_mar = k[0];
      bus_pc  = ~k[0];
      @(negedge clk);
      check("halted_ready0", rr[0], 0);
      check("halted_ready1", rr[1], 0);
    end
    bus_mar = 1'b0; bus_pc = 1'b0;
    halt = 1'b0;
    repeat (5) @(negedge clk);
    check("unhalt_ready0", rr[0], 0);
    check("unhalt_ready1", rr[1], 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("halt_reset");
    ref_mar = 8'h00; ref_perr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    w = 16'hAB05;
    send_word(T_PC, w);
    wait_idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
